// File: rtl/random_pkg.sv
//------------------------------------------------------------------------------
// Module : random_pkg
// Brief  : Shared LFSR constants and step function for the game's random sources.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package random_pkg;

  localparam int          c_lfsr_w            = 16;
  localparam logic [15:0] c_lfsr_mask         = 16'hB400;
  localparam logic [15:0] c_lfsr_seed_default = 16'hACE1;

  // One Galois right-shift step of x^16+x^14+x^13+x^11+1.
  function automatic logic [c_lfsr_w-1:0] lfsr_next(input logic [c_lfsr_w-1:0] s);
    logic [c_lfsr_w-1:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ c_lfsr_mask;
    return n;
  endfunction

  // The all-zero state is a fixed point, so it can never be used as a seed.
  function automatic logic [c_lfsr_w-1:0] seed_sanitize(input logic [c_lfsr_w-1:0] s);
    return (s == '0) ? {{(c_lfsr_w-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/random_lfsr.sv
//------------------------------------------------------------------------------
// Module : random_lfsr
// Brief  : Free-running 16-bit Galois LFSR with seed load and lockout recovery.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module random_lfsr
  import random_pkg::*;
#(
  parameter logic [15:0] SEED = c_lfsr_seed_default
) (
  input  logic                Clk,
  input  logic                Rst,
  output logic [c_lfsr_w-1:0] state
);

  localparam logic [c_lfsr_w-1:0] c_seed = seed_sanitize(SEED);

  logic [c_lfsr_w-1:0] r_state;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= c_seed;
    end else if (r_state == '0) begin
      r_state <= c_seed;
    end else begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/random.sv
//------------------------------------------------------------------------------
// Module : random
// Brief  : Latches a (optionally range-mapped) LFSR byte on each rising req.
//          Range mapping is enabled by defining RANDOM_RANGE_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module random
  import random_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = c_lfsr_seed_default,
  parameter logic [7:0]  NUM_MIN   = 8'd20,
  parameter logic [7:0]  NUM_MAX   = 8'd180
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       req,
  output logic [7:0] Num
);

  logic [c_lfsr_w-1:0] w_lfsr;
  logic [7:0]          w_raw;
  logic [7:0]          w_mapped;
  logic                w_req_rise;
  logic                r_req_d;
  logic                w_unused;

  random_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .state (w_lfsr)
  );

  assign w_raw      = w_lfsr[7:0];
  assign w_req_rise = req & ~r_req_d;

`ifdef RANDOM_RANGE_EN
  localparam logic [8:0] c_span    = {1'b0, NUM_MAX} - {1'b0, NUM_MIN} + 9'd1;
  localparam logic [7:0] c_num_rst = NUM_MIN;

  logic [16:0] w_prod;

  // raw*span >> 8 never exceeds span-1, so the sum stays within NUM_MAX.
  assign w_prod   = {9'd0, w_raw} * {8'd0, c_span};
  assign w_mapped = NUM_MIN + w_prod[15:8];
  assign w_unused = ^{w_prod[16], w_prod[7:0], w_lfsr[15:8]};
`else
  localparam logic [7:0] c_num_rst = 8'd0;

  assign w_mapped = w_raw;
  assign w_unused = ^{w_lfsr[15:8], NUM_MIN, NUM_MAX};
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_req_d <= 1'b0;
      Num     <= c_num_rst;
    end else begin
      r_req_d <= req;
      if (w_req_rise) Num <= w_mapped;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_random.sv
//------------------------------------------------------------------------------
// Module : tb_random
// Brief  : Self-checking bench for random against a behavioural reference.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_random;

  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          MIN_V   = 20;
  localparam int          MAX_V   = 180;
`ifdef RANDOM_RANGE_EN
  localparam logic [7:0]  RST_NUM = 8'd20;
  localparam logic [7:0]  FIRST   = 8'd161;
`else
  localparam logic [7:0]  RST_NUM = 8'd0;
  localparam logic [7:0]  FIRST   = 8'd225;
`endif

  logic       Clk;
  logic       Rst;
  logic       req;
  logic [7:0] Num;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  logic        m_req_d;
  logic [7:0]  m_num;

  random dut (
    .Clk (Clk),
    .Rst (Rst),
    .req (req),
    .Num (Num)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] ref_next(input logic [15:0] s);
    if (s == 16'h0) return SEED;
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [7:0] ref_map(input logic [7:0] raw);
`ifdef RANDOM_RANGE_EN
    int span;
    span = MAX_V - MIN_V + 1;
    return 8'(MIN_V + (int'(raw) * span) / 256);
`else
    return raw;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic q);
    Rst = r;
    req = q;
    @(posedge Clk);
    if (r) begin
      m_lfsr  = SEED;
      m_req_d = 1'b0;
      m_num   = RST_NUM;
    end else begin
      if (q && !m_req_d) m_num = ref_map(m_lfsr[7:0]);
      m_req_d = q;
      m_lfsr  = ref_next(m_lfsr);
    end
    #1;
    check("num", {8'd0, Num}, {8'd0, m_num});
    check("lfsr", dut.w_lfsr, m_lfsr);
  endtask

  initial begin
    int   reqs;
    logic prev_q;
    logic q;
    logic zero_seen;
    logic [7:0] held;

    Rst = 1'b1;
    req = 1'b0;
    m_lfsr = SEED; m_req_d = 1'b0; m_num = RST_NUM;

    step(1, 0);
    step(1, 0);
    check("reset_num", {8'd0, Num}, {8'd0, RST_NUM});
    check("reset_lfsr", dut.w_lfsr, 16'hACE1);
    step(0, 0);
    check("idle_num", {8'd0, Num}, {8'd0, RST_NUM});
    check("first_step", dut.w_lfsr, 16'hE270);

    // Request already high at the first post-reset edge.
    step(1, 0);
    step(0, 1);
    check("first_req", {8'd0, Num}, {8'd0, FIRST});

    held = Num;
    for (int i = 0; i < 50; i++) step(0, 1);
    check("held_const", {8'd0, Num}, {8'd0, held});
    step(0, 0);
    step(0, 1);
    step(0, 1);

    reqs   = 0;
    prev_q = 1'b1;
    while (reqs < 1000) begin
      q = ($urandom_range(0, 2) == 0);
      step(0, q);
      if (q && !prev_q) reqs++;
      prev_q = q;
`ifdef RANDOM_RANGE_EN
      check("range", {15'd0, (int'(Num) >= MIN_V) && (int'(Num) <= MAX_V)}, 16'd1);
`endif
    end

    // Reset wins over a simultaneous rising request.
    step(0, 0);
    step(1, 1);
    check("rst_prio_num", {8'd0, Num}, {8'd0, RST_NUM});
    check("rst_prio_lfsr", dut.w_lfsr, 16'hACE1);
    step(0, 1);
    check("replay", {8'd0, Num}, {8'd0, FIRST});

    step(1, 0);
    zero_seen = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      step(0, 0);
      if (dut.w_lfsr == 16'h0) zero_seen = 1'b1;
    end
    check("period", dut.w_lfsr, 16'hACE1);
    check("never_zero", {15'd0, zero_seen}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
